wb_arbiter3: RTL and testbench
==============================

# wb_arbiter3

Three-master, one-slave Wishbone arbiter between the CPU's memory clients and the system bus. Masters are the instruction fetcher (M0), the load unit (M1) and the store unit (M2). The arbiter grants the bus to one master at a time with fixed priority and holds the grant for that master's whole cycle. It routes ack/err back only to the owner and can abort hung transfers with a watchdog.

## Interface
Parameters:
- `TIMEOUT`, default 255: watchdog limit in cycles; legal range 1..65535.

Ports:
- `i_clk`, input, 1: clock.
- `i_reset`, input, 1: reset, synchronous, active-high.
- `i_mN_cyc`, input, 1 (N=0,1,2): master N requests or holds the bus.
- `i_mN_stb`, input, 4: master N byte strobes. Nonzero means a transfer is pending.
- `i_mN_we`, input, 1: master N write enable.
- `i_mN_addr`, input, 32: master N address.
- `i_mN_dat`, input, 32: master N write data.
- `o_mN_ack`, output, 1: transfer complete, to the owner only.
- `o_mN_err`, output, 1: transfer failed, to the owner only.
- `o_m_dat`, output, 32: read data, equal to `i_wb_dat`, shared by all masters.
- `o_wb_cyc`, `o_wb_stb[3:0]`, `o_wb_we`, `o_wb_addr[31:0]`, `o_wb_dat[31:0]`, outputs: slave-side bus.
- `i_wb_dat[31:0]`, `i_wb_ack`, `i_wb_err`, inputs: slave responses.
- `o_grant`, output, 2: owner index. 3 means idle.
- `o_timeout`, output, 1: one-cycle pulse when the watchdog fires.

## Operation
- State register `owner`: IDLE (`o_grant`=3), or GNT0, GNT1, GNT2.
- IDLE:
  - If any `i_mN_cyc` is high, go to GNTk, where k is the lowest N with cyc high. Priority is M0 > M1 > M2.
  - Otherwise stay in IDLE.
- GNTk:
  - Slave outputs are driven combinationally from master k.
  - `o_wb_cyc` = `i_mk_cyc` and not `aborted`.
  - `o_wb_stb` = `i_mk_stb` when not `aborted`, else 0.
  - `o_wb_we`, `o_wb_addr` and `o_wb_dat` are taken from master k.
- Outside GNTk (i.e. in IDLE): all slave outputs are 0.
- Ack/err routing:
  - `o_mk_ack` = `i_wb_ack` and not `i_wb_err`.
  - `o_mk_err` = `i_wb_err`, or the watchdog firing.
  - Both are gated to the owner and to `o_wb_cyc` high.
  - Non-owners always see 0.
  - Slave ack/err received while IDLE is ignored.
- Ack and err in the same cycle: err only.
- Release:
  - In GNTk, if `i_mk_cyc` is low, go to IDLE.
  - There is always at least one IDLE cycle between owners. No same-cycle regrant.
- Back-to-back transfers: the owner keeps cyc high and presents new stb after each ack.
- Grant is never preempted by a higher-priority request.
- Reset (any state, mid-transfer included):
  - `owner`=IDLE, watchdog counter 0, `aborted`=0.
  - All outputs 0, `o_grant`=3, the same cycle reset is sampled.

## Timing
- Arbitration latency: `i_mN_cyc` rising in cycle t gives `o_wb_cyc` high in t+1. The earliest ack to the master is in t+1, from a zero-wait slave.
- Ack/err path is combinational, slave to master, with zero added latency.
- Release: `i_mk_cyc` low in cycle t makes `o_wb_cyc` low in t. IDLE is registered at t+1, and a new grant is effective at t+2.
- Watchdog:
  - The counter increments each cycle in GNTk with `o_wb_stb` nonzero and no ack/err.
  - It clears on ack, err, or stb=0.
  - When it is at `TIMEOUT`-1 and no ack/err is present, the same cycle asserts `o_mk_err` and `o_timeout` and sets `aborted`.
  - Ack arriving in the firing cycle wins: normal ack, no timeout.
- `aborted` holds `o_wb_cyc`/`o_wb_stb` at 0 until the owner drops cyc, then clears on the return to IDLE.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined: watchdog, `aborted` flag and `o_timeout` are implemented as above. The counter is 16 bits wide.
- Not defined:
  - No counter and no `aborted` logic.
  - `o_timeout` is tied to 0.
  - A hung slave stalls the owner indefinitely.
  - `TIMEOUT` is ignored.

## Test plan
- Single read: M1 cyc with stb=4'hF and addr 0x100, slave acks 2 cycles later with dat 0xDEADBEEF. Expect `o_grant`=1, `o_m1_ack` for 1 cycle, `o_m_dat`=0xDEADBEEF, then IDLE after M1 drops cyc.
- Contention: M0, M1 and M2 raise cyc in the same cycle, each doing one transfer and dropping cyc. Expect grant order 0, 1, 2, with exactly one IDLE cycle between grants and no ack seen by non-owners.
- No preemption: M2 owns the bus and is waiting. M0 requests mid-transfer. Expect `o_grant` to stay 2 until M2 drops cyc, then go to 0 two cycles later.
- Err precedence: a slave asserts ack and err together for M0. Expect `o_m0_err`=1 and `o_m0_ack`=0.
- Watchdog, with the macro defined and `TIMEOUT`=8: the slave never acks. Expect `o_m1_err` and `o_timeout` in the 8th stb cycle, `o_wb_cyc` low afterwards, and IDLE after M1 drops cyc. Without the macro: no err after 100 cycles.
- Reset mid-transfer: assert `i_reset` during GNT1 with stb active. Next cycle expect all outputs 0, `o_grant`=3, and an immediate clean regrant afterwards.

Source files
------------

// File: rtl/wb_arbiter3.sv
// wb_arbiter3: fixed-priority (M0 > M1 > M2) Wishbone arbiter, three masters to one slave.
// The grant is held for the owner's whole cycle, and there is always one idle cycle between owners.
// Ack/err are routed combinationally back to the owner only.
// Optional watchdog, enabled by defining WB_ARB_TIMEOUT_EN, aborts transfers the slave never answers.
module wb_arbiter3 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_cyc,
    input  logic [3:0]  i_m0_stb,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_dat,
    input  logic        i_m1_cyc,
    input  logic [3:0]  i_m1_stb,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_dat,
    input  logic        i_m2_cyc,
    input  logic [3:0]  i_m2_stb,
    input  logic        i_m2_we,
    input  logic [31:0] i_m2_addr,
    input  logic [31:0] i_m2_dat,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic        o_m2_ack,
    output logic        o_m2_err,
    output logic [31:0] o_m_dat,
    output logic        o_wb_cyc,
    output logic [3:0]  o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    localparam logic [1:0] StGnt0 = 2'd0;
    localparam logic [1:0] StGnt1 = 2'd1;
    localparam logic [1:0] StGnt2 = 2'd2;
    localparam logic [1:0] StIdle = 2'd3;

    logic [1:0]  owner_q, owner_d;
    logic        sel_cyc, sel_we;
    logic [3:0]  sel_stb;
    logic [31:0] sel_addr, sel_dat;
    logic        granted, aborted, fire, ack_r, err_r;

    // Mux the current owner's request onto internal select lines
    always_comb begin
        sel_cyc  = 1'b0;
        sel_stb  = '0;
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_dat  = '0;
        case (owner_q)
            StGnt0: begin
                sel_cyc = i_m0_cyc; sel_stb = i_m0_stb; sel_we = i_m0_we;
                sel_addr = i_m0_addr; sel_dat = i_m0_dat;
            end
            StGnt1: begin
                sel_cyc = i_m1_cyc; sel_stb = i_m1_stb; sel_we = i_m1_we;
                sel_addr = i_m1_addr; sel_dat = i_m1_dat;
            end
            StGnt2: begin
                sel_cyc = i_m2_cyc; sel_stb = i_m2_stb; sel_we = i_m2_we;
                sel_addr = i_m2_addr; sel_dat = i_m2_dat;
            end
            default: ;
        endcase
    end

    // Reset forces every output to its idle value in the same cycle it is sampled
    assign granted = (owner_q != StIdle) && !i_reset;

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        aborted_q, aborted_d;

    assign aborted = aborted_q;
    // Fires only when the slave is silent in the cycle the limit is reached; a late ack wins
    assign fire = o_wb_cyc && (o_wb_stb != 4'd0) && !i_wb_ack && !i_wb_err
                  && (cnt_q == 16'(TIMEOUT - 1));

    // Watchdog counter and abort flag next-state
    always_comb begin
        cnt_d     = '0;
        aborted_d = aborted_q;
        if ((o_wb_stb != 4'd0) && !i_wb_ack && !i_wb_err && !fire) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (fire) begin
            aborted_d = 1'b1;
        end else if (owner_q != StIdle && !sel_cyc) begin
            aborted_d = 1'b0;
        end
    end

    // Watchdog state registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
        end
    end
`else
    assign aborted = 1'b0;
    assign fire    = 1'b0;
`endif

    // Slave-side bus, zero when idle or aborted
    always_comb begin
        o_wb_cyc  = granted && sel_cyc && !aborted;
        o_wb_stb  = (granted && !aborted) ? sel_stb : 4'd0;
        o_wb_we   = granted && sel_we;
        o_wb_addr = granted ? sel_addr : 32'd0;
        o_wb_dat  = granted ? sel_dat : 32'd0;
    end

    // Response routing: err beats ack, both only to the owner while cyc is live
    always_comb begin
        ack_r     = o_wb_cyc && i_wb_ack && !i_wb_err;
        err_r     = o_wb_cyc && (i_wb_err || fire);
        o_m0_ack  = ack_r && (owner_q == StGnt0);
        o_m1_ack  = ack_r && (owner_q == StGnt1);
        o_m2_ack  = ack_r && (owner_q == StGnt2);
        o_m0_err  = err_r && (owner_q == StGnt0);
        o_m1_err  = err_r && (owner_q == StGnt1);
        o_m2_err  = err_r && (owner_q == StGnt2);
        o_m_dat   = i_reset ? 32'd0 : i_wb_dat;
        o_grant   = i_reset ? StIdle : owner_q;
        o_timeout = fire;
    end

    // Owner next-state: grant only from idle, release to idle when the owner drops cyc
    always_comb begin
        owner_d = owner_q;
        if (owner_q == StIdle) begin
            if (i_m0_cyc) begin
                owner_d = StGnt0;
            end else if (i_m1_cyc) begin
                owner_d = StGnt1;
            end else if (i_m2_cyc) begin
                owner_d = StGnt2;
            end
        end else if (!sel_cyc) begin
            owner_d = StIdle;
        end
    end

    // Owner state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            owner_q <= StIdle;
        end else begin
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter3.sv
// Self-checking bench for wb_arbiter3: per-cycle vector table, expectations queued at drive
// time and popped at the falling edge for comparison.
module tb_wb_arbiter3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cyc;
    logic [3:0]  stb [3];
    logic        wb_ack, wb_err;
    logic [31:0] wb_rdat;
    logic [2:0]  mack, merr;
    logic [31:0] m_dat, wb_addr, wb_dat;
    logic        wb_cyc, wb_we, timeout;
    logic [3:0]  wb_stb;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    wb_arbiter3 #(.TIMEOUT(8)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_cyc(cyc[0]), .i_m0_stb(stb[0]), .i_m0_we(1'b0),
        .i_m0_addr(32'h0000_0000), .i_m0_dat(32'hA000_0000),
        .i_m1_cyc(cyc[1]), .i_m1_stb(stb[1]), .i_m1_we(1'b0),
        .i_m1_addr(32'h0000_0100), .i_m1_dat(32'hA000_0001),
        .i_m2_cyc(cyc[2]), .i_m2_stb(stb[2]), .i_m2_we(1'b1),
        .i_m2_addr(32'h0000_0200), .i_m2_dat(32'hA000_0002),
        .o_m0_ack(mack[0]), .o_m0_err(merr[0]),
        .o_m1_ack(mack[1]), .o_m1_err(merr[1]),
        .o_m2_ack(mack[2]), .o_m2_err(merr[2]),
        .o_m_dat(m_dat),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_addr(wb_addr), .o_wb_dat(wb_dat),
        .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
        .o_grant(grant), .o_timeout(timeout)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  cyc;
        logic [3:0]  stb;
        logic        ack;
        logic        err;
        logic [31:0] rdat;
        logic [1:0]  g;
        logic [2:0]  eack;
        logic [2:0]  eerr;
        logic        ecyc;
        logic        eto;
    } vec_t;

    typedef struct {
        int          row;
        logic [1:0]  g;
        logic [2:0]  ack;
        logic [2:0]  err;
        logic        cyc;
        logic [3:0]  stb;
        logic        we;
        logic [31:0] addr;
        logic [31:0] dat;
        logic [31:0] mdat;
        logic        to;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(logic r, logic [2:0] c, logic [3:0] s, logic a, logic e,
                                logic [31:0] rd, logic [1:0] g, logic [2:0] ea,
                                logic [2:0] ee, logic ec, logic eto);
        vec_t v;
        v.rst = r; v.cyc = c; v.stb = s; v.ack = a; v.err = e; v.rdat = rd;
        v.g = g; v.eack = ea; v.eerr = ee; v.ecyc = ec; v.eto = eto;
        return v;
    endfunction

    task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    initial begin
        exp_t x;
        rst = 1'b1; cyc = '0; wb_ack = 0; wb_err = 0; wb_rdat = '0;
        for (int n = 0; n < 3; n++) stb[n] = '0;

        // reset
        vecs.push_back(mk(1, 3'b000, 4'h0, 0, 0, 32'h0, 3, 0, 0, 0, 0));
        // single read by M1, ack two cycles after grant
        vecs.push_back(mk(0, 3'b010, 4'hF, 0, 0, 32'h0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b010, 4'hF, 0, 0, 32'h0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b010, 4'hF, 0, 0, 32'h0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b010, 4'hF, 1, 0, 32'hDEADBEEF, 1, 3'b010, 0, 1, 0));
        vecs.push_back(mk(0, 3'b000, 4'h0, 0, 0, 32'h0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 4'h0, 1, 0, 32'h5, 3, 0, 0, 0, 0));
        // contention: grant order 0,1,2 with one idle cycle between owners
        vecs.push_back(mk(0, 3'b111, 4'hF, 0, 0, 32'h0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b111, 4'hF, 1, 0, 32'h10, 0, 3'b001, 0, 1, 0));
        vecs.push_back(mk(0, 3'b110, 4'hF, 0, 0, 32'h0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b110, 4'hF, 0, 0, 32'h0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b110, 4'h3, 1, 0, 32'h11, 1, 3'b010, 0, 1, 0));
        vecs.push_back(mk(0, 3'b100, 4'h3, 0, 0, 32'h0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b100, 4'hC, 0, 0, 32'h0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b100, 4'hC, 1, 0, 32'h12, 2, 3'b100, 0, 1, 0));
        vecs.push_back(mk(0, 3'b000, 4'h0, 0, 0, 32'h0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 4'h0, 0, 0, 32'h0, 3, 0, 0, 0, 0));
        // no preemption: M0 asks while M2 owns
        vecs.push_back(mk(0, 3'b100, 4'hF, 0, 0, 32'h0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b100, 4'hF, 0, 0, 32'h0, 2, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b101, 4'hF, 0, 0, 32'h0, 2, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b101, 4'hF, 1, 0, 32'h20, 2, 3'b100, 0, 1, 0));
        vecs.push_back(mk(0, 3'b001, 4'hF, 0, 0, 32'h0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 4'hF, 0, 0, 32'h0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 4'hF, 0, 0, 32'h0, 0, 0, 0, 1, 0));
        // ack and err together: err only
        vecs.push_back(mk(0, 3'b001, 4'hF, 1, 1, 32'h0, 0, 0, 3'b001, 1, 0));
        vecs.push_back(mk(0, 3'b000, 4'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 4'h0, 0, 0, 32'h0, 3, 0, 0, 0, 0));
        // reset mid-transfer, then clean regrant
        vecs.push_back(mk(0, 3'b010, 4'hF, 0, 0, 32'h0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b010, 4'hF, 0, 0, 32'h0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 3'b010, 4'hF, 1, 0, 32'h77, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b010, 4'hF, 0, 0, 32'h0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b010, 4'hF, 0, 0, 32'h0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b010, 4'hF, 1, 0, 32'h30, 1, 3'b010, 0, 1, 0));
        vecs.push_back(mk(0, 3'b000, 4'h0, 0, 0, 32'h0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 4'h0, 0, 0, 32'h0, 3, 0, 0, 0, 0));

        // hung slave on M1
        vecs.push_back(mk(0, 3'b010, 4'hF, 0, 0, 32'h0, 3, 0, 0, 0, 0));
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mk(0, 3'b010, 4'hF, 0, 0, 32'h0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3'b010, 4'hF, 0, 0, 32'h0, 1, 0, 3'b010, 1, 1));
        vecs.push_back(mk(0, 3'b010, 4'hF, 0, 0, 32'h0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b010, 4'hF, 0, 0, 32'h0, 1, 0, 0, 0, 0));
`else
        for (int i = 1; i <= 100; i++)
            vecs.push_back(mk(0, 3'b010, 4'hF, 0, 0, 32'h0, 1, 0, 0, 1, 0));
`endif
        vecs.push_back(mk(0, 3'b000, 4'h0, 0, 0, 32'h0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 4'h0, 0, 0, 32'h0, 3, 0, 0, 0, 0));

        #1;
        for (int r = 0; r < vecs.size(); r++) begin
            vec_t v;
            v = vecs[r];
            rst = v.rst; cyc = v.cyc; wb_ack = v.ack; wb_err = v.err; wb_rdat = v.rdat;
            for (int n = 0; n < 3; n++) stb[n] = v.cyc[n] ? v.stb : 4'h0;
            x.row  = r;
            x.g    = v.g;
            x.ack  = v.eack;
            x.err  = v.eerr;
            x.cyc  = v.ecyc;
            x.stb  = v.ecyc ? v.stb : 4'h0;
            x.we   = (v.g == 2'd2);
            x.addr = (v.g == 2'd3) ? 32'h0 : 32'h100 * 32'(v.g);
            x.dat  = (v.g == 2'd3) ? 32'h0 : 32'hA000_0000 + 32'(v.g);
            x.mdat = v.rst ? 32'h0 : v.rdat;
            x.to   = v.eto;
            sb.push_back(x);

            @(negedge clk);
            x = sb.pop_front();
            chk("grant", x.row, 32'(grant), 32'(x.g));
            chk("ack", x.row, 32'(mack), 32'(x.ack));
            chk("err", x.row, 32'(merr), 32'(x.err));
            chk("wb_cyc", x.row, 32'(wb_cyc), 32'(x.cyc));
            chk("wb_stb", x.row, 32'(wb_stb), 32'(x.stb));
            chk("wb_we", x.row, 32'(wb_we), 32'(x.we));
            chk("wb_addr", x.row, wb_addr, x.addr);
            chk("wb_dat", x.row, wb_dat, x.dat);
            chk("m_dat", x.row, m_dat, x.mdat);
            chk("timeout", x.row, 32'(timeout), 32'(x.to));
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
